// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 checker and the companion generator:
// state encoding, polynomial taps and the error-count width.
package prbs31_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int PRBS_LEN  = 31;
  localparam int TAP_A     = 30;
  localparam int TAP_B     = 27;
  localparam int ERR_CNT_W = 16;

  // Next bit of x^31 + x^28 + 1 given the current shift register.
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment leaves the count at one.
module prbs31_sat_cnt
  import prbs31_pkg::*;
#(
  parameter int WIDTH = ERR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count register: reset, then clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: fills and self-synchronises on the incoming stream,
// then free-runs and flags mismatches, dropping lock on a burst of errors.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT = 64,
  parameter int WIN_LEN  = 256,
  parameter int LOSS_THR = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 loss_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBIT_W  = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);
  localparam logic [4:0]         FILL_LAST = 5'(PRBS_LEN - 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WBIT_W-1:0]  WIN_LAST  = WBIT_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  LOSS_LAST = WERR_W'(LOSS_THR - 1);

  state_t                state_r, state_n;
  logic [PRBS_LEN-1:0]   s_r, s_n;
  logic [4:0]            fill_r, fill_n;
  logic [MATCH_W-1:0]    match_r, match_n;
  logic [WBIT_W-1:0]     wbits_r, wbits_n;
  logic [WERR_W-1:0]     werr_r, werr_n;
  logic                  locked_r, err_pulse_r, loss_pulse_r;
  logic                  pred, err_s, loss_s;

  assign pred = prbs_predict(s_r);

  // Next-state logic; nothing moves on cycles without a valid bit.
  always_comb begin
    state_n = state_r;
    s_n     = s_r;
    fill_n  = fill_r;
    match_n = match_r;
    wbits_n = wbits_r;
    werr_n  = werr_r;
    err_s   = 1'b0;
    loss_s  = 1'b0;
    if (din_valid) begin
      case (state_r)
        ST_FILL: begin
          s_n = {s_r[PRBS_LEN-2:0], din};
          if (fill_r == FILL_LAST) begin
            state_n = ST_SYNC;
            fill_n  = 5'd0;
            match_n = '0;
          end else begin
            fill_n = fill_r + 5'd1;
          end
        end
        ST_SYNC: begin
          s_n = {s_r[PRBS_LEN-2:0], din};
          if (din != pred) begin
            match_n = '0;
          end else if (s_r == '0) begin
            match_n = match_r;   // an all-zero register predicts nothing
          end else if (match_r == LOCK_LAST) begin
            state_n = ST_LOCKED;
            match_n = '0;
            wbits_n = '0;
            werr_n  = '0;
          end else begin
            match_n = match_r + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          s_n   = {s_r[PRBS_LEN-2:0], pred};
          err_s = (din != pred);
          // Loss wins over a window restart on the same bit.
          if (err_s && (werr_r == LOSS_LAST)) begin
            state_n = ST_FILL;
            fill_n  = 5'd0;
            loss_s  = 1'b1;
          end else if (wbits_r == WIN_LAST) begin
            wbits_n = '0;
            werr_n  = '0;
          end else begin
            wbits_n = wbits_r + WBIT_W'(1);
            werr_n  = werr_r + WERR_W'(err_s);
          end
        end
        default: begin
          state_n = ST_FILL;
          fill_n  = 5'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, shift register, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_FILL;
      s_r          <= '0;
      fill_r       <= 5'd0;
      match_r      <= '0;
      wbits_r      <= '0;
      werr_r       <= '0;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      loss_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      s_r          <= s_n;
      fill_r       <= fill_n;
      match_r      <= match_n;
      wbits_r      <= wbits_n;
      werr_r       <= werr_n;
      locked_r     <= (state_n == ST_LOCKED);
      err_pulse_r  <= err_s;
      loss_pulse_r <= loss_s;
    end
  end

  prbs31_sat_cnt #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (err_s),
    .count (err_count)
  );

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign loss_pulse = loss_pulse_r;
  assign state      = state_r;

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: directed scenarios plus a random
// phase, compared against a bit-history reference model.
module tb_prbs31_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, din, din_valid, clr_cnt;
  logic        locked, err_pulse, loss_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  logic        s_rst, s_din, s_valid, s_clr;
  logic        s_locked, s_err_pulse, s_loss_pulse;
  logic [15:0] s_err_count;
  logic [1:0]  s_state;

  prbs31_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .loss_pulse(loss_pulse),
    .err_count(err_count), .state(state)
  );

  // Small-window instance that can never lose lock, used to saturate err_count.
  prbs31_checker #(.LOCK_CNT(8), .WIN_LEN(4), .LOSS_THR(8)) dut_sat (
    .clk(clk), .rst(s_rst), .din(s_din), .din_valid(s_valid), .clr_cnt(s_clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .loss_pulse(s_loss_pulse),
    .err_count(s_err_count), .state(s_state)
  );

  int errors = 0;
  int checks = 0;

  logic [30:0] gen = 31'h7FFFFFFF;
  logic [20:0] obs;
  assign obs = {state, locked, err_pulse, loss_pulse, err_count};

  // Reference model: last 31 register bits kept as a queue, oldest first.
  int   m_state, m_fill, m_match, m_wbits, m_werr, m_cnt;
  logic m_ep, m_lp;
  logic hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic next_bit(output logic b);
    b   = gen[30] ^ gen[27];
    gen = {gen[29:0], b};
  endtask

  task automatic push_bit(input logic b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0; m_cnt = 0;
    m_ep = 1'b0; m_lp = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic v, input logic c);
    logic p, e;
    bit   zero;
    e = 1'b0;
    m_lp = 1'b0;
    if (v) begin
      p = hist[0] ^ hist[3];   // bit 31 ago XOR bit 28 ago
      if (m_state == 0) begin
        push_bit(d);
        m_fill++;
        if (m_fill == 31) begin m_state = 1; m_fill = 0; m_match = 0; end
      end else if (m_state == 1) begin
        zero = 1'b1;
        foreach (hist[i]) if (hist[i]) zero = 1'b0;
        if (d !== p) m_match = 0;
        else if (!zero) m_match++;
        push_bit(d);
        if (m_match == 64) begin m_state = 2; m_wbits = 0; m_werr = 0; end
      end else begin
        e = (d !== p);
        push_bit(p);
        m_wbits++;
        m_werr += int'(e);
        if (m_werr == 16) begin m_state = 0; m_fill = 0; m_lp = 1'b1; end
        else if (m_wbits == 256) begin m_wbits = 0; m_werr = 0; end
      end
    end
    m_ep = e;
    if (c) m_cnt = int'(e);
    else if (e && m_cnt < 65535) m_cnt++;
  endtask

  function automatic logic [20:0] model_exp();
    return {2'(m_state), (m_state == 2), m_ep, m_lp, 16'(m_cnt)};
  endfunction

  task automatic step(input logic d, input logic v, input logic c);
    din = d; din_valid = v; clr_cnt = c;
    model_step(d, v, c);
    @(posedge clk); #1;
    check("cycle", 32'(obs), 32'(model_exp()));
  endtask

  task automatic clean(input logic v);
    logic b;
    if (v) begin next_bit(b); step(b, 1'b1, 1'b0); end
    else step(1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; din = 1'($urandom); din_valid = 1'b1; clr_cnt = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset", 32'(obs), 32'h0);
  endtask

  // Feeds clean bits (continuous or 1,0,0,1 gapped) until lock, bounded.
  task automatic feed_until_lock(input bit gapped, output int nvalid);
    logic v;
    nvalid = 0;
    for (int i = 0; i < 1000 && !locked; i++) begin
      v = gapped ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (v) nvalid++;
      clean(v);
    end
  endtask

  initial begin
    int   n, np, nl;
    logic b;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    s_rst = 1'b1; s_din = 1'b0; s_valid = 1'b0; s_clr = 1'b0;
    @(posedge clk); #1;

    // Saturation on the small-window instance while the main one sits in reset.
    s_rst = 1'b0; s_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && !s_locked; i++) begin
      next_bit(b); s_din = b; @(posedge clk); #1; n++;
    end
    check("sat_lock_len", 32'(n), 32'd39);
    repeat (65540) begin next_bit(b); s_din = ~b; @(posedge clk); #1; end
    check("sat_count", 32'(s_err_count), 32'hFFFF);
    check("sat_locked", 32'(s_locked), 32'd1);
    next_bit(b); s_din = ~b; s_clr = 1'b1; @(posedge clk); #1;
    check("clr_with_err", 32'(s_err_count), 32'd1);
    check("clr_err_pulse", 32'(s_err_pulse), 32'd1);
    next_bit(b); s_din = b; @(posedge clk); #1;
    check("clr_no_err", 32'(s_err_count), 32'd0);
    check("sat_no_loss", 32'({s_state, s_loss_pulse}), 32'({2'd2, 1'b0}));
    s_clr = 1'b0; s_valid = 1'b0;

    // Clean stream: lock latency and long error-free run.
    do_reset();
    feed_until_lock(1'b0, n);
    check("lock_len", 32'(n), 32'd95);
    repeat (10000 - 95) clean(1'b1);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_locked", 32'(locked), 32'd1);

    // Three single flips spaced 100 bits apart.
    np = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (99) begin clean(1'b1); np += int'(err_pulse); end
      next_bit(b); step(~b, 1'b1, 1'b0); np += int'(err_pulse);
    end
    clean(1'b1); np += int'(err_pulse);
    check("flip_pulses", 32'(np), 32'd3);
    check("flip_count", 32'(err_count), 32'd3);
    check("flip_locked", 32'(locked), 32'd1);

    // Burst of 16 inside one window after clearing the count.
    next_bit(b); step(b, 1'b1, 1'b1);
    for (int i = 0; i < 300 && m_wbits != 0; i++) clean(1'b1);
    nl = 0;
    repeat (16) begin next_bit(b); step(~b, 1'b1, 1'b0); nl += int'(loss_pulse); end
    check("burst_state", 32'(state), 32'd0);
    check("burst_count", 32'(err_count), 32'd16);
    clean(1'b1); nl += int'(loss_pulse);
    check("burst_loss_once", 32'(nl), 32'd1);
    feed_until_lock(1'b0, n);
    check("relock_len", 32'(n + 1), 32'd95);
    check("relock_count_held", 32'(err_count), 32'd16);

    // Clear coincident with an error, then reset while locked.
    next_bit(b); step(~b, 1'b1, 1'b1);
    check("main_clr_with_err", 32'(err_count), 32'd1);
    do_reset();

    // All-zero stream never locks.
    repeat (500) step(1'b0, 1'b1, 1'b0);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_state", 32'(state), 32'd1);

    // Gapped valid reaches lock after the same number of valid bits.
    do_reset();
    feed_until_lock(1'b1, n);
    check("gapped_lock_len", 32'(n), 32'd95);
    check("gapped_err_count", 32'(err_count), 32'd0);

    // Random gaps, flips, error bursts and clears against the model.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      repeat (600) begin
        logic v, f, c;
        v = ($urandom_range(0, 3) != 0);
        f = ($urandom_range(0, 39) == 0);
        c = ($urandom_range(0, 99) == 0);
        if (v) begin next_bit(b); step(b ^ f, 1'b1, c); end
        else step(1'($urandom), 1'b0, c);
      end
      repeat (40) begin
        next_bit(b); step(b ^ 1'($urandom), 1'b1, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 Parameter LOCK_CNT, default 64: consecutive matching bits required to declare lock.
REQ-002 Parameter WIN_LEN, default 256: window length, in valid bits, used for loss-of-lock evaluation.
REQ-003 Parameter LOSS_THR, default 16: errors within one window that force loss of lock.
REQ-004 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port din, input, 1: received serial PRBS31 bit.
REQ-007 Port din_valid, input, 1: din is sampled only when high; low cycles are fully ignored.
REQ-008 Port clr_cnt, input, 1: synchronous clear of err_count.
REQ-009 Port locked, output, 1: checker is in LOCKED state.
REQ-010 Port err_pulse, output, 1: one-cycle pulse per mismatched bit while LOCKED.
REQ-011 Port loss_pulse, output, 1: one-cycle pulse on transition LOCKED to FILL.
REQ-012 Port err_count, output, 16: saturating count of errors flagged while LOCKED.
REQ-013 Port state, output, 2: current state encoding (FILL=0, SYNC=1, LOCKED=2).

Function
REQ-014 Polynomial x^31+x^28+1; register s[30:0]; predicted bit p = s[30] XOR s[27]; every shift is s <= {s[29:0], b}.
REQ-015 FILL: on each valid bit, b = din; fill counter increments; after the 31st valid bit, next state is SYNC with the match counter at 0.
REQ-016 SYNC: on each valid bit, b = din (self-synchronising); din == p increments the match counter; din != p resets it to 0.
REQ-017 SYNC: the match counter does not increment while s == 0; an all-zero stream never locks.
REQ-018 SYNC to LOCKED occurs on the clock edge that registers the LOCK_CNT-th consecutive match; locked goes high on that edge.
REQ-019 LOCKED: b = p (free-running); din is compared only, never shifted in.
REQ-020 LOCKED: if din != p, err_pulse is high on the next cycle.
REQ-021 LOCKED: if din != p, the window error counter increments and err_count increments, saturating at 16'hFFFF.
REQ-022 LOCKED: the window bit counter counts valid bits; on reaching WIN_LEN it and the window error counter both restart at 0.
REQ-023 The window error counter reaching LOSS_THR causes next state FILL with fill counter 0, plus a loss_pulse for one cycle.
REQ-024 If the LOSS_THR-th error and the WIN_LEN-th bit coincide, loss of lock takes precedence.
REQ-025 clr_cnt high sets err_count to 0; if an error occurs in the same cycle, err_count becomes 1.
REQ-026 err_count holds its value across lock loss and relock; only clr_cnt or rst clears it.
REQ-027 din_valid low: no counter, register or state changes occur; err_pulse and loss_pulse are 0.
REQ-028 All outputs are registered; no combinational path exists from any input to any output.

Reset
REQ-029 rst high for one edge sets state FILL, s = 0, all counters = 0, locked = 0, err_pulse = 0, loss_pulse = 0, err_count = 0.
REQ-030 rst takes precedence over din_valid and clr_cnt, including mid-lock.
REQ-031 After rst deasserts, the checker requires 31 plus LOCK_CNT valid bits before locked can assert.

Structure
REQ-032 Package prbs31_pkg holds the state enum, PRBS_LEN = 31, TAP_A = 30, TAP_B = 27, and the 16-bit error-count width; the future generator reuses the same package.
REQ-033 Saturating counter with synchronous clear and same-cycle increment is a sub-module, prbs31_sat_cnt, used for err_count.

Verification
REQ-034 Clean stream: generator seed 31'h7FFFFFFF, din_valid=1 continuously -> locked high exactly 31+64 = 95 valid bits after rst release; err_count = 0 after 10000 bits.
REQ-035 Single injected flips: invert 3 bits, spaced 100 apart, after lock -> 3 err_pulse cycles, err_count = 3, locked stays 1.
REQ-036 Burst: invert 16 consecutive bits after lock -> loss_pulse once, state = FILL, err_count = 16; clean stream afterwards relocks after 95 valid bits.
REQ-037 All-zero din for 500 bits after reset -> locked stays 0 and state remains SYNC.
REQ-038 Gapped valid: din_valid toggling 1,0,0,1 on the clean stream -> lock reached after 95 valid bits, identical to REQ-034; err_count = 0.
REQ-039 Boundaries: err_count preloaded via 65535 errors stays at 16'hFFFF; clr_cnt coincident with an error -> err_count = 1; rst mid-lock -> all outputs zero on the next cycle.
